// File: rtl/cfgreg_arbiter.sv
// cfgreg_arbiter: round-robin arbiter sharing one config register port among N_REQ requesters, with lock and lock timeout
module cfgreg_arbiter #(
   parameter int N_REQ          = 2,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int LOCK_TIMEOUT   = 16
) (
   input  logic                              clk_i,
   input  logic                              rstn_i,
   input  logic [N_REQ-1:0]                  req_valid_i,
   output logic [N_REQ-1:0]                  req_ready_o,
   input  logic [N_REQ-1:0]                  req_wen_i,
   input  logic [N_REQ-1:0]                  req_lock_i,
   input  logic [N_REQ*12-1:0]               req_offset_i,
   input  logic [N_REQ*AXI_DATA_WIDTH-1:0]   req_wdata_i,
   output logic [N_REQ-1:0]                  rsp_valid_o,
   input  logic [N_REQ-1:0]                  rsp_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]         rsp_rdata_o,
   output logic [11:0]                       config_offset_o,
   output logic                              config_wen_o,
   output logic [AXI_DATA_WIDTH-1:0]         config_wdata_o,
   input  logic [AXI_DATA_WIDTH-1:0]         config_rdata_i,
   output logic [$clog2(N_REQ)-1:0]          grant_id_o,
   output logic                              lock_active_o,
   output logic                              lock_timeout_o
);

   localparam int IW = $clog2(N_REQ);
   localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                    state_q, state_d;
   logic [IW-1:0]             ptr_q, ptr_d;
   logic [IW-1:0]             grant_q, grant_d;
   logic                      wen_q, wen_d;
   logic                      lock_req_q, lock_req_d;
   logic [11:0]               offset_q, offset_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      lock_q, lock_d;
   logic [IW-1:0]             owner_q, owner_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic                      timeout_q, timeout_d;

   logic [N_REQ-1:0]          cand;
   logic [IW-1:0]             win;
   logic                      found;

   // candidate mask and cyclic first-valid search starting just after the last winner
   always_comb begin
      cand  = req_valid_i & (lock_q ? (N_REQ'(1) << owner_q) : {N_REQ{1'b1}});
      win   = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   // accept strobe goes only to the winner, and only while idle
   always_comb begin
      req_ready_o = '0;
      if (state_q == IDLE && found) req_ready_o[win] = 1'b1;
   end

   // next-state: transaction sequencing, lock bookkeeping and idle-lock timer
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      wen_d      = wen_q;
      lock_req_d = lock_req_q;
      offset_d   = offset_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      lock_d     = lock_q;
      owner_d    = owner_q;
      timer_d    = timer_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d    = ISSUE;
               ptr_d      = win;
               grant_d    = win;
               wen_d      = req_wen_i[win];
               lock_req_d = req_lock_i[win];
               offset_d   = req_offset_i[int'(win)*12 +: 12];
               wdata_d    = req_wdata_i[int'(win)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
               timer_d    = '0;
               if (req_lock_i[win]) begin
                  lock_d  = 1'b1;
                  owner_d = win;
               end
            end else if (lock_q && LOCK_TIMEOUT != 0) begin
               // owner is the only candidate while locked, so no winner means the owner is idle
               timer_d = timer_q + TW'(1);
               if (timer_d == TW'(LOCK_TIMEOUT)) begin
                  lock_d    = 1'b0;
                  timer_d   = '0;
                  timeout_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            rdata_d = wen_q ? '0 : config_rdata_i;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i[grant_q]) begin
               state_d = IDLE;
               if (lock_q && owner_q == grant_q && !lock_req_q) begin
                  lock_d  = 1'b0;
                  timer_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state register with asynchronous clear; in-flight work is dropped on reset
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         ptr_q      <= IW'(N_REQ - 1);
         grant_q    <= '0;
         wen_q      <= 1'b0;
         lock_req_q <= 1'b0;
         offset_q   <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         lock_q     <= 1'b0;
         owner_q    <= '0;
         timer_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         wen_q      <= wen_d;
         lock_req_q <= lock_req_d;
         offset_q   <= offset_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         lock_q     <= lock_d;
         owner_q    <= owner_d;
         timer_q    <= timer_d;
         timeout_q  <= timeout_d;
      end
   end

   assign config_offset_o = (state_q == ISSUE) ? offset_q : '0;
   assign config_wen_o    = (state_q == ISSUE) ? wen_q : 1'b0;
   assign config_wdata_o  = (state_q == ISSUE) ? wdata_q : '0;
   assign rsp_valid_o     = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
   assign rsp_rdata_o     = rdata_q;
   assign grant_id_o      = grant_q;
   assign lock_active_o   = lock_q;
   assign lock_timeout_o  = timeout_q;

endmodule
